control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter OPCODE_W, default 8: opcode width (>=5).
REQ-002 Parameter ALUOP_W, default 3: ALUOP width (>=3).
REQ-003 Parameter CNT_W, default 16: RETIRED counter width.
REQ-004 Parameter TIMEOUT, default 255: maximum BUSYWAIT cycles tolerated per memory access.
REQ-005 CLK  input  1  single clock; all state updates on the rising edge.
REQ-006 RESET  input  1  asynchronous, active-low reset.
REQ-007 INSTR_VALID  input  1  OPCODE is valid.
REQ-008 OPCODE  input  OPCODE_W  instruction opcode.
REQ-009 INSTR_READY  output  1  sequencer can accept an instruction.
REQ-010 BUSYWAIT  input  1  data memory is still busy.
REQ-011 WRITEENABLE, ALUSRC, NEMUX, JUMP, BRANCH, MEM_READ, MEM_WRITE  output  1 each  registered control strobes.
REQ-012 ALUOP  output  ALUOP_W  ALU select: 0 forward, 1 add/sub, 2 AND, 3 OR (4..7 under REQ-030).
REQ-013 ILLEGAL  output  1  one-cycle pulse for an unsupported opcode.
REQ-014 MEM_ERR  output  1  one-cycle pulse on a memory timeout.
REQ-015 RETIRED  output  CNT_W  count of completed instructions.

Function
REQ-016 States: IDLE, DECODE, EXEC, MEM, WB; INSTR_READY SHALL be high only in IDLE.
REQ-017 Handshake: opcode SHALL be latched when INSTR_VALID & INSTR_READY; IDLE->DECODE; OPCODE changes outside IDLE SHALL be ignored.
REQ-018 Decode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 MOV, 5 LOADI, 6 J, 7 BEQ, 8 LWD, 9 LWI, 10 SWD, 11 SWI; all other values illegal.
REQ-019 DECODE SHALL last one cycle and drive ALUOP/ALUSRC/NEMUX: ADD 1/1/0, SUB 1/1/1, AND 2/1/0, OR 3/1/0, MOV 0/1/0, LOADI 0/0/0, BEQ 1/1/1, J 0/1/0, LWD/SWD 0/1/0, LWI/SWI 0/0/0.
REQ-020 ALU ops (0-5): DECODE->EXEC; WRITEENABLE high during EXEC only; EXEC->IDLE; READY returns 3 cycles after acceptance.
REQ-021 J: JUMP high during EXEC; BEQ: BRANCH high during EXEC; no WRITEENABLE; EXEC->IDLE.
REQ-022 Loads/stores: DECODE->MEM; MEM_READ (8,9) or MEM_WRITE (10,11) SHALL be held high in MEM while BUSYWAIT=1 and in the first cycle MEM is entered.
REQ-023 MEM exit on BUSYWAIT=0 sampled in MEM: loads->WB with WRITEENABLE high one cycle then IDLE; stores->IDLE.
REQ-024 Timeout: a counter SHALL count MEM cycles with BUSYWAIT=1; on reaching TIMEOUT, MEM_ERR pulses, strobes drop, ->IDLE, no WRITEENABLE, RETIRED unchanged.
REQ-025 Illegal opcode: in DECODE, ILLEGAL pulses, all strobes low, ->IDLE, RETIRED unchanged.
REQ-026 RETIRED SHALL increment by 1 on the final cycle of every legal completed instruction, wrapping from 2^CNT_W-1 to 0.
REQ-027 Strobes SHALL never be high in IDLE or DECODE; MEM_READ and MEM_WRITE SHALL never be high simultaneously.

Reset
REQ-028 RESET low SHALL asynchronously force IDLE, clear the latched opcode, timeout counter and RETIRED, drive all strobes, ILLEGAL and MEM_ERR low, ALUOP 0, ALUSRC 0, and set INSTR_READY high.
REQ-029 Reset mid-operation (any state) SHALL abort with no completion: no WRITEENABLE, no RETIRED increment.

Configuration
REQ-030 Macro CU_EXT_OPS_EN defined: opcodes 12 MUL, 13 SLL, 14 SRL, 15 ROR are legal ALU ops with ALUOP 4/5/6/7, ALUSRC 1, EXEC timing per REQ-020; undefined: 12-15 are illegal per REQ-025.

Verification
REQ-031 After reset, OPCODE=0 with VALID for 1 cycle -> WRITEENABLE=1, ALUOP=1, NEMUX=0 exactly 2 cycles after acceptance; READY high at +3; RETIRED=1.
REQ-032 OPCODE=8, BUSYWAIT high 4 cycles -> MEM_READ high 5 cycles, WRITEENABLE 1 cycle in WB, RETIRED +1.
REQ-033 OPCODE=10, BUSYWAIT held high, TIMEOUT=4 -> MEM_ERR pulse after 4 busy cycles, no write, READY high next cycle, RETIRED unchanged.
REQ-034 OPCODE=13 -> ILLEGAL pulse, no strobes without CU_EXT_OPS_EN; with it, ALUOP=5 and WRITEENABLE in EXEC.
REQ-035 RESET low during MEM of OPCODE=9 -> all outputs reset immediately, no WRITEENABLE after release, RETIRED=0.
REQ-036 CNT_W=2, 5 consecutive ADDs -> RETIRED sequence 1,2,3,0,1.

Source files
------------

// File: rtl/control_sequencer_if.sv
// Instruction/memory handshake and control-strobe bundle for control_sequencer.
// master: instruction source / memory model side; slave: the sequencer.
interface control_sequencer_if #(
  parameter int OPCODE_W = 8,
  parameter int ALUOP_W  = 3,
  parameter int CNT_W    = 16
);
  logic                instr_valid;
  logic [OPCODE_W-1:0] opcode;
  logic                instr_ready;
  logic                busywait;
  logic                writeenable;
  logic                alusrc;
  logic                nemux;
  logic                jump;
  logic                branch;
  logic                mem_read;
  logic                mem_write;
  logic [ALUOP_W-1:0]  aluop;
  logic                illegal;
  logic                mem_err;
  logic [CNT_W-1:0]    retired;

  modport master (
    output instr_valid, opcode, busywait,
    input  instr_ready, writeenable, alusrc, nemux, jump, branch,
           mem_read, mem_write, aluop, illegal, mem_err, retired
  );

  modport slave (
    input  instr_valid, opcode, busywait,
    output instr_ready, writeenable, alusrc, nemux, jump, branch,
           mem_read, mem_write, aluop, illegal, mem_err, retired
  );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle instruction control sequencer: IDLE -> DECODE -> EXEC | MEM (-> WB).
// All control outputs are registered; a memory access that stays busy for
// TIMEOUT cycles is aborted with a mem_err pulse.
// Optional feature macro: CU_EXT_OPS_EN (opcodes 12..15 become MUL/SLL/SRL/ROR).
module control_sequencer #(
  parameter int OPCODE_W = 8,
  parameter int ALUOP_W  = 3,
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  control_sequencer_if.slave   bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_e;
  typedef enum logic [2:0] {K_ILL, K_ALU, K_JMP, K_BR, K_LD, K_ST} kind_e;

  typedef struct packed {
    kind_e              kind;
    logic [ALUOP_W-1:0] aluop;
    logic               alusrc;
    logic               nemux;
  } dec_t;

  function automatic dec_t mk(input kind_e k, input int a, input logic s, input logic n);
    dec_t d;
    d.kind   = k;
    d.aluop  = ALUOP_W'(a);
    d.alusrc = s;
    d.nemux  = n;
    return d;
  endfunction

  function automatic dec_t decode(input logic [OPCODE_W-1:0] op);
    dec_t d;
    d = mk(K_ILL, 0, 1'b0, 1'b0);
    case (op)
      OPCODE_W'(0):  d = mk(K_ALU, 1, 1'b1, 1'b0); // ADD
      OPCODE_W'(1):  d = mk(K_ALU, 1, 1'b1, 1'b1); // SUB
      OPCODE_W'(2):  d = mk(K_ALU, 2, 1'b1, 1'b0); // AND
      OPCODE_W'(3):  d = mk(K_ALU, 3, 1'b1, 1'b0); // OR
      OPCODE_W'(4):  d = mk(K_ALU, 0, 1'b1, 1'b0); // MOV
      OPCODE_W'(5):  d = mk(K_ALU, 0, 1'b0, 1'b0); // LOADI
      OPCODE_W'(6):  d = mk(K_JMP, 0, 1'b1, 1'b0); // J
      OPCODE_W'(7):  d = mk(K_BR,  1, 1'b1, 1'b1); // BEQ
      OPCODE_W'(8):  d = mk(K_LD,  0, 1'b1, 1'b0); // LWD
      OPCODE_W'(9):  d = mk(K_LD,  0, 1'b0, 1'b0); // LWI
      OPCODE_W'(10): d = mk(K_ST,  0, 1'b1, 1'b0); // SWD
      OPCODE_W'(11): d = mk(K_ST,  0, 1'b0, 1'b0); // SWI
`ifdef CU_EXT_OPS_EN
      OPCODE_W'(12): d = mk(K_ALU, 4, 1'b1, 1'b0); // MUL
      OPCODE_W'(13): d = mk(K_ALU, 5, 1'b1, 1'b0); // SLL
      OPCODE_W'(14): d = mk(K_ALU, 6, 1'b1, 1'b0); // SRL
      OPCODE_W'(15): d = mk(K_ALU, 7, 1'b1, 1'b0); // ROR
`endif
      default:       d = mk(K_ILL, 0, 1'b0, 1'b0);
    endcase
    return d;
  endfunction

  state_e              state;
  logic [OPCODE_W-1:0] op_q;
  logic [TW-1:0]       tcnt;
  dec_t                acc;   // decode of the incoming opcode, used at acceptance
  dec_t                dec;   // decode of the latched opcode, steers DECODE/MEM

  assign acc = decode(bus.opcode);
  assign dec = decode(op_q);

  // Ready is a pure function of the state register, so it is high only in IDLE.
  assign bus.instr_ready = (state == S_IDLE);

  // Sequencer state, registered strobes, timeout counter and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      op_q            <= '0;
      tcnt            <= '0;
      bus.retired     <= '0;
      bus.writeenable <= 1'b0;
      bus.jump        <= 1'b0;
      bus.branch      <= 1'b0;
      bus.mem_read    <= 1'b0;
      bus.mem_write   <= 1'b0;
      bus.aluop       <= '0;
      bus.alusrc      <= 1'b0;
      bus.nemux       <= 1'b0;
      bus.illegal     <= 1'b0;
      bus.mem_err     <= 1'b0;
    end else begin
      bus.illegal <= 1'b0;
      bus.mem_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.instr_valid) begin
            // ALU selects are visible during DECODE, so load them on acceptance.
            op_q        <= bus.opcode;
            bus.aluop   <= acc.aluop;
            bus.alusrc  <= acc.alusrc;
            bus.nemux   <= acc.nemux;
            bus.illegal <= (acc.kind == K_ILL);
            state       <= S_DECODE;
          end
        end
        S_DECODE: begin
          case (dec.kind)
            K_ALU: begin bus.writeenable <= 1'b1; state <= S_EXEC; end
            K_JMP: begin bus.jump        <= 1'b1; state <= S_EXEC; end
            K_BR:  begin bus.branch      <= 1'b1; state <= S_EXEC; end
            K_LD:  begin bus.mem_read    <= 1'b1; tcnt <= '0; state <= S_MEM; end
            K_ST:  begin bus.mem_write   <= 1'b1; tcnt <= '0; state <= S_MEM; end
            default: state <= S_IDLE;
          endcase
        end
        S_EXEC: begin
          bus.writeenable <= 1'b0;
          bus.jump        <= 1'b0;
          bus.branch      <= 1'b0;
          bus.aluop       <= '0;
          bus.alusrc      <= 1'b0;
          bus.nemux       <= 1'b0;
          bus.retired     <= bus.retired + CNT_W'(1);
          state           <= S_IDLE;
        end
        S_MEM: begin
          if (bus.busywait) begin
            // Abort once TIMEOUT busy cycles have been seen in this access.
            if (tcnt == TW'(TIMEOUT - 1)) begin
              bus.mem_err   <= 1'b1;
              bus.mem_read  <= 1'b0;
              bus.mem_write <= 1'b0;
              bus.aluop     <= '0;
              bus.alusrc    <= 1'b0;
              bus.nemux     <= 1'b0;
              state         <= S_IDLE;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end else begin
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            if (dec.kind == K_LD) begin
              bus.writeenable <= 1'b1;
              state           <= S_WB;
            end else begin
              bus.aluop   <= '0;
              bus.alusrc  <= 1'b0;
              bus.nemux   <= 1'b0;
              bus.retired <= bus.retired + CNT_W'(1);
              state       <= S_IDLE;
            end
          end
        end
        S_WB: begin
          bus.writeenable <= 1'b0;
          bus.aluop       <= '0;
          bus.alusrc      <= 1'b0;
          bus.nemux       <= 1'b0;
          bus.retired     <= bus.retired + CNT_W'(1);
          state           <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: one default instance (ifa) and one
// with TIMEOUT=4, CNT_W=2 (ifb), both driven by the same stimulus.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] opcode = 8'd0;
  logic       busy = 1'b0;

  int n_chk = 0;
  int n_fail = 0;
  int rd_cnt;
  int we_cnt;

  always #5 clk = ~clk;

  control_sequencer_if #(.OPCODE_W(8), .ALUOP_W(3), .CNT_W(16)) ifa ();
  control_sequencer_if #(.OPCODE_W(8), .ALUOP_W(3), .CNT_W(2))  ifb ();

  assign ifa.instr_valid = valid;
  assign ifa.opcode      = opcode;
  assign ifa.busywait    = busy;
  assign ifb.instr_valid = valid;
  assign ifb.opcode      = opcode;
  assign ifb.busywait    = busy;

  control_sequencer #(.OPCODE_W(8), .ALUOP_W(3), .CNT_W(16), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifa));

  control_sequencer #(.OPCODE_W(8), .ALUOP_W(3), .CNT_W(2), .TIMEOUT(4)) dut_t (
    .clk(clk), .rst_n(rst_n), .bus(ifb));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // One acceptance cycle; afterwards the DUT sits in DECODE.
  task automatic issue(input logic [7:0] op);
    valid  = 1'b1;
    opcode = op;
    tick();
    valid  = 1'b0;
    opcode = 8'hff;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_ready",   ifa.instr_ready, 1);
    check("rst_we",      ifa.writeenable, 0);
    check("rst_aluop",   ifa.aluop, 0);
    check("rst_alusrc",  ifa.alusrc, 0);
    check("rst_retired", ifa.retired, 0);
    check("rst_flags",   {ifa.illegal, ifa.mem_err, ifa.mem_read, ifa.mem_write}, 0);

    // ADD: decode at +1, write at +2, ready/retire at +3
    issue(8'd0);
    check("add_d_ready", ifa.instr_ready, 0);
    check("add_d_we",    ifa.writeenable, 0);
    check("add_d_alu",   {ifa.aluop, ifa.alusrc, ifa.nemux}, {3'd1, 1'b1, 1'b0});
    tick();
    check("add_e_we",    ifa.writeenable, 1);
    check("add_e_alu",   {ifa.aluop, ifa.nemux}, {3'd1, 1'b0});
    tick();
    check("add_ready",   ifa.instr_ready, 1);
    check("add_we_off",  ifa.writeenable, 0);
    check("add_retired", ifa.retired, 1);

    // SUB: nemux set
    issue(8'd1);
    check("sub_d_alu", {ifa.aluop, ifa.alusrc, ifa.nemux}, {3'd1, 1'b1, 1'b1});
    tick();
    check("sub_e_we", ifa.writeenable, 1);
    tick();
    check("sub_retired", ifa.retired, 2);

    // J: jump strobe in EXEC, no write
    issue(8'd6);
    tick();
    check("j_e", {ifa.jump, ifa.branch, ifa.writeenable}, 3'b100);
    tick();
    check("j_done", {ifa.jump, ifa.instr_ready}, 2'b01);
    check("j_retired", ifa.retired, 3);

    // BEQ: branch strobe
    issue(8'd7);
    check("beq_d_alu", {ifa.aluop, ifa.alusrc, ifa.nemux}, {3'd1, 1'b1, 1'b1});
    tick();
    check("beq_e", {ifa.jump, ifa.branch, ifa.writeenable}, 3'b010);
    tick();
    check("beq_retired", ifa.retired, 4);

    // LOADI: immediate source
    issue(8'd5);
    check("ldi_d_alu", {ifa.aluop, ifa.alusrc, ifa.nemux}, {3'd0, 1'b0, 1'b0});
    tick();
    check("ldi_e_we", ifa.writeenable, 1);
    tick();
    check("ldi_retired", ifa.retired, 5);

    // LWD with 4 busy cycles: mem_read for 5 cycles, then WB
    issue(8'd8);
    busy = 1'b1;
    rd_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 4) busy = 1'b0;
      rd_cnt += int'(ifa.mem_read);
      if (ifa.mem_write) rd_cnt += 100;
    end
    check("lwd_read_cycles", rd_cnt, 5);
    tick();
    check("lwd_wb", {ifa.writeenable, ifa.mem_read}, 2'b10);
    tick();
    check("lwd_done", {ifa.writeenable, ifa.instr_ready}, 2'b01);
    check("lwd_retired", ifa.retired, 6);

    // SWD, not busy: one MEM cycle, no write-back
    issue(8'd10);
    tick();
    check("swd_mem", {ifa.mem_write, ifa.mem_read}, 2'b10);
    tick();
    check("swd_done", {ifa.mem_write, ifa.writeenable, ifa.instr_ready}, 3'b001);
    check("swd_retired", ifa.retired, 7);

    // Opcode 13: extension-dependent
    issue(8'd13);
`ifdef CU_EXT_OPS_EN
    check("op13_d", {ifa.illegal, ifa.aluop, ifa.alusrc}, {1'b0, 3'd5, 1'b1});
    tick();
    check("op13_e_we", ifa.writeenable, 1);
    tick();
    check("op13_retired", ifa.retired, 8);
`else
    check("op13_ill", {ifa.illegal, ifa.writeenable, ifa.aluop}, {1'b1, 1'b0, 3'd0});
    tick();
    check("op13_done", {ifa.illegal, ifa.instr_ready, ifa.writeenable}, 3'b010);
    check("op13_retired", ifa.retired, 7);
`endif

    // Opcode 20 is always illegal
    do_reset();
    issue(8'd20);
    check("op20_ill", ifa.illegal, 1);
    tick();
    check("op20_quiet", {ifa.illegal, ifa.writeenable, ifa.jump, ifa.branch,
                         ifa.mem_read, ifa.mem_write}, 0);
    check("op20_retired", ifa.retired, 0);

    // SWD timeout on the TIMEOUT=4 instance
    do_reset();
    busy = 1'b1;
    issue(8'd10);
    tick();
    check("to_mem", ifb.mem_write, 1);
    for (int i = 0; i < 3; i++) tick();
    check("to_no_err_yet", ifb.mem_err, 0);
    tick();
    check("to_err", {ifb.mem_err, ifb.mem_write, ifb.writeenable}, 3'b100);
    tick();
    check("to_after", {ifb.mem_err, ifb.instr_ready}, 2'b01);
    check("to_retired", ifb.retired, 0);
    busy = 1'b0;

    // Reset during MEM of LWI
    do_reset();
    busy = 1'b1;
    issue(8'd9);
    tick();
    check("rm_mem", ifa.mem_read, 1);
    tick();
    rst_n = 1'b0;
    #1;
    check("rm_async", {ifa.mem_read, ifa.instr_ready, ifa.aluop, ifa.alusrc}, {1'b0, 1'b1, 3'd0, 1'b0});
    busy = 1'b0;
    tick();
    rst_n = 1'b1;
    we_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      we_cnt += int'(ifa.writeenable);
    end
    check("rm_no_we", we_cnt, 0);
    check("rm_retired", ifa.retired, 0);

    // CNT_W=2 wrap over five ADDs
    do_reset();
    begin
      logic [1:0] exp_seq [5];
      exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      for (int i = 0; i < 5; i++) begin
        issue(8'd0);
        tick();
        tick();
        check($sformatf("wrap_%0d", i), ifb.retired, exp_seq[i]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
